// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and MEM-stage data access.
// Optional macro ARB_FAIR_EN adds a fairness flag that lets a waiting fetch beat data after a data grant.

`ifndef BUS_NONE
`define BUS_NONE  2'b00
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'b01
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'b10
`endif

module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic [1:0]  dm_cmd,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic [1:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        arb_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bus_cmd_q, bus_cmd_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        arb_err_q, arb_err_d;
  logic        dm_valid;
  logic        pick_data;
  logic        finish;
  logic        timed_out;

  // The illegal encoding 2'b11 never requests the bus
  assign dm_valid = (dm_cmd == `BUS_LOAD) || (dm_cmd == `BUS_STORE);

`ifdef ARB_FAIR_EN
  logic fair_q, fair_d;
  assign pick_data = dm_valid && !(if_req && fair_q);
`else
  assign pick_data = dm_valid;
`endif

  assign timed_out = !bus_ack && (cnt_q == CNT_LAST);
  assign finish    = bus_ack || timed_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_cmd_d   = bus_cmd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    arb_err_d   = arb_err_q;
`ifdef ARB_FAIR_EN
    fair_d      = fair_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (pick_data) begin
          state_d     = S_DATA;
          bus_cmd_d   = dm_cmd;
          bus_addr_d  = dm_addr;
          bus_wdata_d = (dm_cmd == `BUS_STORE) ? dm_wdata : 32'd0;
        end else if (if_req) begin
          state_d     = S_FETCH;
          bus_cmd_d   = `BUS_LOAD;
          bus_addr_d  = if_addr;
          bus_wdata_d = 32'd0;
        end
      end
      S_FETCH, S_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (finish) begin
          state_d     = S_DONE;
          bus_cmd_d   = `BUS_NONE;
          bus_wdata_d = 32'd0;
          arb_err_d   = timed_out;
          if (state_q == S_FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = timed_out ? 32'd0 : bus_rdata;
`ifdef ARB_FAIR_EN
            fair_d     = 1'b0;
`endif
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = (timed_out || bus_cmd_q == `BUS_STORE) ? 32'd0 : bus_rdata;
`ifdef ARB_FAIR_EN
            fair_d     = 1'b1;
`endif
          end
        end
      end
      default: begin
        // DONE lasts one cycle; requests are not looked at until IDLE
        state_d   = S_IDLE;
        arb_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_cmd_q   <= `BUS_NONE;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      arb_err_q   <= 1'b0;
`ifdef ARB_FAIR_EN
      fair_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_cmd_q   <= bus_cmd_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      arb_err_q   <= arb_err_d;
`ifdef ARB_FAIR_EN
      fair_q      <= fair_d;
`endif
    end
  end

  assign bus_cmd   = bus_cmd_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign arb_err   = arb_err_q;

endmodule
